// File: rtl/alu_pkg.sv
// Opcode constants and sequencer state encoding shared by the ALU front-end.
package alu_pkg;

  localparam logic [4:0] OP_SHL = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00011;
  localparam logic [4:0] OP_MUL = 5'b00100;
  localparam logic [4:0] OP_DIV = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01100;
  localparam logic [4:0] OP_SHR = 5'b10000;
  localparam logic [4:0] OP_NOP = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    ISSUE_HI,
    CAP_LO,
    CAP_HI,
    RESP
  } seq_state_t;

  function automatic logic is_div_by_zero(input logic [4:0] op, input logic [3:0] b);
    return (op == OP_DIV) && (b == 4'h0);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Classifies an opcode as legal or not, and as needing one or two ALU halves.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [4:0] op,
  output logic       legal,
  output logic       two_half
);

  always_comb begin
    legal    = 1'b0;
    two_half = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        legal    = 1'b1;
        two_half = 1'b1;
      end
      OP_AND, OP_OR, OP_SHL, OP_SHR: begin
        legal    = 1'b1;
        two_half = 1'b0;
      end
      default: begin
        legal    = 1'b0;
        two_half = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response front-end that issues one or two halves to the registered
// 4-bit ALU and assembles the 8-bit result.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_op,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [4:0] alu_f,
  output logic       alu_v,
  input  logic [3:0] alu_y
);

  seq_state_t state;
  logic       op_legal;
  logic       op_two_half;
  logic       two_half_q;

  alu_op_decode u_decode (
    .op       (req_op),
    .legal    (op_legal),
    .two_half (op_two_half)
  );

  assign req_ready = (state == IDLE);

  // alu_y is registered by the ALU, so each capture happens one edge after
  // the ALU sampled the corresponding f/v; nothing here is combinational on alu_y.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state      <= IDLE;
      two_half_q <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_err    <= 1'b0;
      alu_a      <= 4'h0;
      alu_b      <= 4'h0;
      alu_f      <= OP_NOP;
      alu_v      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          alu_v <= 1'b0;
          if (req_valid) begin
            if (op_legal && !is_div_by_zero(req_op, req_b)) begin
              alu_a      <= req_a;
              alu_b      <= req_b;
              alu_f      <= req_op;
              two_half_q <= op_two_half;
              state      <= ISSUE_LO;
            end else begin
              rsp_data  <= 8'h00;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ISSUE_LO: begin
          if (two_half_q) begin
            alu_v <= 1'b1;
            state <= ISSUE_HI;
          end else begin
            state <= CAP_LO;
          end
        end
        ISSUE_HI: begin
          rsp_data[3:0] <= alu_y;
          alu_v         <= 1'b0;
          state         <= CAP_HI;
        end
        CAP_HI: begin
          rsp_data[7:4] <= alu_y;
          rsp_err       <= 1'b0;
          rsp_valid     <= 1'b1;
          state         <= RESP;
        end
        CAP_LO: begin
          rsp_data  <= {4'h0, alu_y};
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          alu_v     <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer driving a behavioural model of the registered ALU.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_f;
  logic       alu_v;
  logic [3:0] alu_y;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle_count  = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         accept_edge;
    string      name;
  } exp_t;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] data;
    logic       err;
    int         lat;
  } vec_t;

  exp_t exp_q[$];

  alu_sequencer dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_v     (alu_v),
    .alu_y     (alu_y)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle_count <= cycle_count + 1;

  // Registered ALU model: v=0 selects the low nibble, v=1 the high nibble.
  logic [4:0] m_sum;
  logic [4:0] m_diff;
  logic [7:0] m_prod;
  logic [3:0] m_quo;
  logic [3:0] m_rem;

  always_comb begin
    m_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    m_diff = {1'b0, alu_a} - {1'b0, alu_b};
    m_prod = {4'h0, alu_a} * {4'h0, alu_b};
    m_quo  = (alu_b == 4'h0) ? 4'hF : alu_a / alu_b;
    m_rem  = (alu_b == 4'h0) ? alu_a : alu_a % alu_b;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      alu_y <= 4'h0;
    end else begin
      case (alu_f)
        OP_ADD:  alu_y <= alu_v ? {3'b000, m_sum[4]} : m_sum[3:0];
        OP_SUB:  alu_y <= alu_v ? {4{m_diff[4]}} : m_diff[3:0];
        OP_MUL:  alu_y <= alu_v ? m_prod[7:4] : m_prod[3:0];
        OP_DIV:  alu_y <= alu_v ? m_rem : m_quo;
        OP_AND:  alu_y <= alu_a & alu_b;
        OP_OR:   alu_y <= alu_a | alu_b;
        OP_SHL:  alu_y <= {alu_a[2:0], 1'b0};
        OP_SHR:  alu_y <= {1'b0, alu_a[3:1]};
        default: alu_y <= 4'h0;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_req_ready"}, req_ready, 1);
    check_output({tag, "_rsp_valid"}, rsp_valid, 0);
    check_output({tag, "_rsp_data"}, rsp_data, 8'h00);
    check_output({tag, "_rsp_err"}, rsp_err, 0);
    check_output({tag, "_alu_a"}, alu_a, 0);
    check_output({tag, "_alu_b"}, alu_b, 0);
    check_output({tag, "_alu_f"}, alu_f, OP_NOP);
    check_output({tag, "_alu_v"}, alu_v, 0);
  endtask

  task automatic apply_stimulus(input string name, input logic [4:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic [7:0] exp_data, input logic exp_err,
                                input int exp_lat, input bit keep_valid, output int accept_edge);
    int waited = 0;
    exp_t e;
    @(negedge CLK);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    while (!req_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (!req_ready) begin
      check_output({name, "_accept_timeout"}, 0, 1);
      req_valid   = 1'b0;
      accept_edge = -1;
      return;
    end
    accept_edge   = cycle_count + 1;
    e.data        = exp_data;
    e.err         = exp_err;
    e.lat         = exp_lat;
    e.accept_edge = accept_edge;
    e.name        = name;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (!(exp_q.size() == 0 && !rsp_valid && req_ready) && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 100) check_output({name, "_drain_timeout"}, 0, 1);
  endtask

  // Monitor: pop one expectation per response, then watch that it stays stable while stalled.
  initial begin : monitor
    logic       prev_valid;
    logic [7:0] held_data;
    logic       held_err;
    exp_t       e;
    prev_valid = 1'b0;
    held_data  = 8'h00;
    held_err   = 1'b0;
    forever begin
      @(negedge CLK);
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_rsp: got data 0x%0h err %0b, expected no response", rsp_data, rsp_err);
        end else begin
          e = exp_q.pop_front();
          check_output({e.name, "_data"}, rsp_data, e.data);
          check_output({e.name, "_err"}, rsp_err, e.err);
          check_output({e.name, "_latency"}, cycle_count - e.accept_edge, e.lat);
        end
        held_data = rsp_data;
        held_err  = rsp_err;
      end else if (rsp_valid && prev_valid) begin
        check_output("stall_data_stable", rsp_data, held_data);
        check_output("stall_err_stable", rsp_err, held_err);
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    vec_t dir_vecs[9];
    vec_t b2b_vecs[6];
    int   acc;
    int   prev_acc;
    int   rel_edge;
    int   waited;

    dir_vecs[0] = '{"add_14_6", OP_ADD, 4'd14, 4'd6, 8'h14, 1'b0, 3};
    dir_vecs[1] = '{"sub_14_6", OP_SUB, 4'd14, 4'd6, 8'h08, 1'b0, 3};
    dir_vecs[2] = '{"mul_14_6", OP_MUL, 4'd14, 4'd6, 8'h54, 1'b0, 3};
    dir_vecs[3] = '{"div_14_6", OP_DIV, 4'd14, 4'd6, 8'h22, 1'b0, 3};
    dir_vecs[4] = '{"sub_6_14", OP_SUB, 4'd6, 4'd14, 8'hF8, 1'b0, 3};
    dir_vecs[5] = '{"and_14_6", OP_AND, 4'd14, 4'd6, 8'h06, 1'b0, 2};
    dir_vecs[6] = '{"or_14_6",  OP_OR,  4'd14, 4'd6, 8'h0E, 1'b0, 2};
    dir_vecs[7] = '{"shl_14",   OP_SHL, 4'd14, 4'd6, 8'h0C, 1'b0, 2};
    dir_vecs[8] = '{"shr_14",   OP_SHR, 4'd14, 4'd6, 8'h07, 1'b0, 2};

    b2b_vecs[0] = '{"b2b_add_7_9",  OP_ADD, 4'd7,  4'd9,  8'h10, 1'b0, 3};
    b2b_vecs[1] = '{"b2b_shl_9",    OP_SHL, 4'd9,  4'd1,  8'h02, 1'b0, 2};
    b2b_vecs[2] = '{"b2b_sub_3_5",  OP_SUB, 4'd3,  4'd5,  8'hFE, 1'b0, 3};
    b2b_vecs[3] = '{"b2b_nop",      OP_NOP, 4'd1,  4'd1,  8'h00, 1'b1, 0};
    b2b_vecs[4] = '{"b2b_div_13_4", OP_DIV, 4'd13, 4'd4,  8'h13, 1'b0, 3};
    b2b_vecs[5] = '{"b2b_and_12_10", OP_AND, 4'd12, 4'd10, 8'h08, 1'b0, 2};

    CLR       = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_a     = 4'h0;
    req_b     = 4'h0;
    rsp_ready = 1'b1;
    #12;
    check_reset_values("por");
    @(negedge CLK);
    CLR = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(dir_vecs[i].name, dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b,
                     dir_vecs[i].data, dir_vecs[i].err, dir_vecs[i].lat, 1'b0, acc);
      drain(dir_vecs[i].name);
    end
    check_output("last_issue_alu_f", alu_f, OP_SHR);
    check_output("idle_alu_v", alu_v, 0);

    // Errors must not disturb the last issued ALU inputs.
    apply_stimulus("err_nop", OP_NOP, 4'd3, 4'd9, 8'h00, 1'b1, 0, 1'b0, acc);
    drain("err_nop");
    check_output("err_nop_alu_f", alu_f, OP_SHR);
    check_output("err_nop_alu_a", alu_a, 4'd14);
    check_output("err_nop_alu_b", alu_b, 4'd6);
    apply_stimulus("err_div0", OP_DIV, 4'd9, 4'd0, 8'h00, 1'b1, 0, 1'b0, acc);
    drain("err_div0");
    check_output("err_div0_alu_f", alu_f, OP_SHR);
    check_output("err_div0_alu_b", alu_b, 4'd6);

    // Stall the response for five cycles with a follow-up request pending.
    rsp_ready = 1'b0;
    apply_stimulus("stall_add_3_4", OP_ADD, 4'd3, 4'd4, 8'h07, 1'b0, 3, 1'b0, acc);
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check_output("stall_rsp_seen", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_output("stall_req_ready_low", req_ready, 0);
      check_output("stall_rsp_valid_high", rsp_valid, 1);
    end
    req_op    = OP_OR;
    req_a     = 4'd5;
    req_b     = 4'd10;
    req_valid = 1'b1;
    rel_edge  = cycle_count + 1;
    rsp_ready = 1'b1;
    apply_stimulus("pending_or_5_10", OP_OR, 4'd5, 4'd10, 8'h0F, 1'b0, 2, 1'b0, acc);
    check_output("pending_accept_edge", acc, rel_edge + 1);
    drain("pending_or_5_10");

    // Reset in the middle of a MUL, while the high half is being issued.
    apply_stimulus("mul_reset", OP_MUL, 4'd15, 4'd15, 8'hE1, 1'b0, 3, 1'b0, acc);
    @(posedge CLK);
    #2;
    check_output("mul_issue_hi_alu_v", alu_v, 1);
    CLR = 1'b0;
    #1;
    exp_q.delete();
    check_reset_values("midop");
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
    apply_stimulus("post_reset_add_9_8", OP_ADD, 4'd9, 4'd8, 8'h11, 1'b0, 3, 1'b0, acc);
    drain("post_reset_add_9_8");

    // Back-to-back with req_valid held high: next accept is latency + 2 edges later.
    prev_acc = -1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(b2b_vecs[i].name, b2b_vecs[i].op, b2b_vecs[i].a, b2b_vecs[i].b,
                     b2b_vecs[i].data, b2b_vecs[i].err, b2b_vecs[i].lat, 1'b1, acc);
      if (i > 0) check_output({b2b_vecs[i].name, "_bubble"}, acc - prev_acc, b2b_vecs[i-1].lat + 2);
      prev_acc = acc;
    end
    req_valid = 1'b0;
    drain("b2b_end");

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command front-end and initiator for the 4-bit ALU's registered opcode interface (a, b, f, v → y). The block accepts one operation request over a valid/ready handshake and drives the ALU's operands, opcode and half-select. For two-half operations it issues the low half and then the high half, captures both registered y nibbles, and returns a single 8-bit result over a valid/ready response handshake. It sits between a host/test controller and the ALU and shares the ALU's clock; it does not drive the ALU's CLR.

## Interface
Parameters:
- none; all widths are fixed (4-bit operands, 5-bit opcode, 8-bit result).

Ports:
- CLK  in  1  single clock, rising edge, shared with the ALU.
- CLR  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals (state == IDLE).
- req_op  in  5  ALU opcode.
- req_a, req_b  in  4 each  operands.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  8  result.
- rsp_err  out  1  illegal opcode or divide by zero.
- alu_a, alu_b  out  4 each  to ALU a and b; registered.
- alu_f  out  5  to ALU f; registered.
- alu_v  out  1  to ALU v; registered.
- alu_y  in  4  from ALU y, which the ALU registers on the CLK rising edge.

## Operation
- States: IDLE, ISSUE_LO, ISSUE_HI, CAP_LO, CAP_HI, RESP.
- IDLE: on req_valid, latch the operands and decode the opcode.
  - Legal opcode, not divide-by-zero: load alu_a, alu_b and alu_f, set alu_v=0, go to ISSUE_LO.
  - Illegal opcode, or OP_DIV with req_b==0: go to RESP with rsp_data=0x00 and rsp_err=1. The ALU is not issued and alu_* are unchanged.
- Two-half ops are OP_ADD, OP_SUB, OP_MUL and OP_DIV.
  - ISSUE_LO → ISSUE_HI: set alu_v=1.
  - ISSUE_HI → CAP_HI: rsp_data[3:0] ← alu_y.
  - CAP_HI → RESP: rsp_data[7:4] ← alu_y, rsp_err=0.
- Single-half ops are OP_AND, OP_OR, OP_SHL and OP_SHR.
  - ISSUE_LO → CAP_LO.
  - CAP_LO → RESP: rsp_data ← {4'h0, alu_y}, rsp_err=0.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready; then go to IDLE. rsp_valid must not drop before acceptance.
- Result meaning:
  - ADD: 8-bit zero-extended sum; the high nibble is {000, carry}.
  - SUB: a−b as 8-bit two's complement; the high nibble is the borrow replicated.
  - MUL: 8-bit product.
  - DIV: {remainder, quotient}.
- Inputs are ignored outside IDLE; a request held during busy states is accepted only once the block returns to IDLE.
- alu_v=0 in IDLE, RESP and CAP_LO; alu_f and the operands hold their last issued values.

## Timing
- Handshake at edge k (req_valid & req_ready). rsp_valid is asserted after:
  - edge k+3 for two-half ops;
  - edge k+2 for single-half ops;
  - edge k for an error (RESP entered directly at edge k).
- ALU sampling: the ALU samples f/v at edge k+1 (low half) and edge k+2 (high half). The block samples alu_y one edge later each time, so there is no combinational path from alu_y.
- Response handshake completes on the edge with rsp_valid & rsp_ready. The block is in IDLE, with req_ready=1, the following cycle. There is a minimum one-cycle bubble between responses and no request overlap.
- Reset values (asynchronous, on CLR low):
  - state=IDLE, req_ready=1;
  - rsp_valid=0, rsp_data=0x00, rsp_err=0;
  - alu_a=alu_b=0, alu_f=OP_NOP (5'b11111), alu_v=0.
- Reset mid-operation abandons the operation silently; no response is produced.

## Structure
- Package alu_pkg holds the opcode constants:
  - OP_SHL=00000, OP_ADD=00010, OP_SUB=00011, OP_MUL=00100, OP_DIV=00110;
  - OP_AND=01000, OP_OR=01100, OP_SHR=10000, OP_NOP=11111;
  - the state enum.
- One natural sub-module, alu_op_decode: combinational; from op it produces legal and two_half.
- The bench instantiates alu_sequencer with the existing ALU, tying ALU CLR to CLR.

## Test plan
- a=14, b=6: ADD → 0x14; SUB → 0x08; MUL → 0x54; DIV → 0x22. Each has rsp_err=0 and rsp_valid exactly 3 edges after acceptance.
- a=6, b=14, SUB → 0xF8. a=14, b=6: AND → 0x06, OR → 0x0E, SHL → 0x0C, SHR → 0x07, each with latency 2.
- req_op=5'b11111 → rsp_err=1, rsp_data=0x00, no alu_f change. DIV with b=0 → same error response.
- Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_data stay stable and req_ready stays 0. Assert rsp_ready: IDLE next cycle, and a pending request is accepted then.
- Assert CLR low during ISSUE_HI of a MUL: outputs take reset values asynchronously. No response follows; the next ADD after reset returns the correct result.
- Back-to-back requests with req_valid held high and rsp_ready=1: each result is correct, with the required one-cycle bubble.
